// File: rtl/gvt_arbiter_pkg.sv
// rtl/gvt_arbiter_pkg.sv - shared types and helpers for the GVT arbiter
package gvt_arbiter_pkg;

    // Key field widths; the arbiter's TS_WIDTH/TB_WIDTH must match these.
    localparam int GVT_TS_WIDTH = 32;
    localparam int GVT_TB_WIDTH = 32;

    // ts occupies the upper bits so a packed compare is lexicographic.
    typedef struct packed {
        logic [GVT_TS_WIDTH-1:0] ts;
        logic [GVT_TB_WIDTH-1:0] tb;
    } gvt_key_t;

    // An all-ones key marks a tile with no pending work.
    localparam gvt_key_t GVT_INFINITE = '1;

    typedef enum logic [1:0] {
        WAIT,
        COLLECT,
        REDUCE,
        BCAST
    } gvt_state_t;

    // Strict unsigned compare on {ts, tb}; equal keys are "not less".
    function automatic logic key_lt(input gvt_key_t a, input gvt_key_t b);
        return {a.ts, a.tb} < {b.ts, b.tb};
    endfunction

endpackage

// File: rtl/gvt_arbiter.sv
// rtl/gvt_arbiter.sv - periodic GVT poll, sequential min-reduce and broadcast
//
// Every 2^LOG_GVT_PERIOD idle cycles, polls all tiles for their local minimum
// {ts, tb}, reduces the captured keys one tile per cycle with a single
// comparator and broadcasts the minimum as the new GVT.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   enable       permits new rounds (a started round always completes)
//   lvt_req      per-tile request, held until that tile's response is taken
//   lvt_valid    per-tile response valid
//   lvt_ts/tb    per-tile local minimum key, tile i at [i*W +: W]
//   gvt_ts/tb    current GVT
//   gvt_valid    one-cycle pulse when a round broadcasts
//   all_idle     last broadcast round saw every tile empty
//   mono_err     sticky: a computed GVT went backwards (old GVT kept)
//   timeout_err  sticky: a round was abandoned while collecting
//   gvt_rounds   number of broadcasts, wrapping
module gvt_arbiter
    import gvt_arbiter_pkg::*;
#(
    parameter int N_TILES        = 1,
    parameter int TS_WIDTH       = GVT_TS_WIDTH,
    parameter int TB_WIDTH       = GVT_TB_WIDTH,
    parameter int LOG_GVT_PERIOD = 5,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    output logic [N_TILES-1:0]           lvt_req,
    input  logic [N_TILES-1:0]           lvt_valid,
    input  logic [N_TILES*TS_WIDTH-1:0]  lvt_ts,
    input  logic [N_TILES*TB_WIDTH-1:0]  lvt_tb,
    output logic [TS_WIDTH-1:0]          gvt_ts,
    output logic [TB_WIDTH-1:0]          gvt_tb,
    output logic                         gvt_valid,
    output logic                         all_idle,
    output logic                         mono_err,
    output logic                         timeout_err,
    output logic [31:0]                  gvt_rounds
);

    localparam int IDX_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LOG_GVT_PERIOD-1:0] PERIOD_MAX = '1;

    gvt_state_t                state, state_next;
    logic [LOG_GVT_PERIOD-1:0] period_cnt;
    logic [TO_W-1:0]           timeout_cnt;
    logic [N_TILES-1:0]        got;
    logic [N_TILES-1:0]        accept;
    logic [N_TILES-1:0]        req_next;
    logic [IDX_W-1:0]          idx;
    gvt_key_t                  keys [N_TILES];
    gvt_key_t                  acc, acc_next;
    gvt_key_t                  gvt_q;
    logic                      got_full;
    logic                      timeout_hit;
    logic                      last_idx;

    assign accept      = lvt_req & lvt_valid;
    assign got_full    = &got;
    assign timeout_hit = (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign last_idx    = (idx == IDX_W'(N_TILES - 1));
    assign acc_next    = key_lt(keys[idx], acc) ? keys[idx] : acc;

    assign gvt_ts = gvt_q.ts;
    assign gvt_tb = gvt_q.tb;

    always_comb begin
        state_next = state;
        case (state)
            WAIT:    if (period_cnt == PERIOD_MAX && enable) state_next = COLLECT;
            COLLECT: begin
                if (got_full)         state_next = REDUCE;
                else if (timeout_hit) state_next = WAIT;
            end
            REDUCE:  if (last_idx) state_next = BCAST;
            BCAST:   state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    // Requests are only raised from inside COLLECT, so they appear one cycle
    // after entry and drop on the same edge that records the acceptance.
    always_comb begin
        req_next = '0;
        if (state == COLLECT && state_next == COLLECT) begin
            req_next = ~(got | accept);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT;
            period_cnt  <= '0;
            timeout_cnt <= '0;
            lvt_req     <= '0;
            got         <= '0;
            idx         <= '0;
            acc         <= GVT_INFINITE;
            gvt_q       <= '0;
            gvt_valid   <= 1'b0;
            all_idle    <= 1'b0;
            mono_err    <= 1'b0;
            timeout_err <= 1'b0;
            gvt_rounds  <= '0;
        end else begin
            state     <= state_next;
            lvt_req   <= req_next;
            gvt_valid <= 1'b0;
            case (state)
                WAIT: begin
                    if (period_cnt != PERIOD_MAX) begin
                        period_cnt <= period_cnt + 1'b1;
                    end else if (enable) begin
                        period_cnt <= '0;
                    end
                end
                COLLECT: begin
                    got         <= got | accept;
                    timeout_cnt <= timeout_cnt + 1'b1;
                    if (got_full) begin
                        timeout_cnt <= '0;
                        acc         <= GVT_INFINITE;
                        idx         <= '0;
                    end else if (timeout_hit) begin
                        timeout_cnt <= '0;
                        got         <= '0;
                        timeout_err <= 1'b1;
                    end
                end
                REDUCE: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    // The final reduction step publishes the result so the
                    // GVT is already stable for the whole BCAST cycle.
                    if (last_idx) begin
                        gvt_valid  <= 1'b1;
                        gvt_rounds <= gvt_rounds + 32'd1;
                        all_idle   <= (acc_next == GVT_INFINITE);
                        if (key_lt(acc_next, gvt_q)) begin
                            mono_err <= 1'b1;
                        end else begin
                            gvt_q <= acc_next;
                        end
                    end
                end
                BCAST: got <= '0;
                default: ;
            endcase
        end
    end

    // Key registers keep their contents across rounds and reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_TILES; i++) begin
            if (accept[i]) begin
                keys[i].ts <= lvt_ts[i*TS_WIDTH +: TS_WIDTH];
                keys[i].tb <= lvt_tb[i*TB_WIDTH +: TB_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_gvt_arbiter.sv
// tb/tb_gvt_arbiter.sv - self-checking bench for gvt_arbiter
module tb_gvt_arbiter;

    localparam int N   = 4;
    localparam int NV  = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [N-1:0]    lvt_req;
    logic [N-1:0]    lvt_valid;
    logic [N*32-1:0] lvt_ts;
    logic [N*32-1:0] lvt_tb;
    logic [31:0]     gvt_ts, gvt_tb, gvt_rounds;
    logic            gvt_valid, all_idle, mono_err, timeout_err;

    logic [31:0] tile_ts [N];
    logic [31:0] tile_tb [N];
    int          dly  [N];
    bit          mute [N];
    int          age  [N];

    int cyc    = 0;
    int base   = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ts  [N];
        logic [31:0] tb  [N];
        int          dly [N];
        logic [31:0] ets;
        logic [31:0] etb;
        bit          eidle;
        bit          emono;
    } vec_t;

    vec_t vecs [NV];

    gvt_arbiter #(
        .N_TILES(N), .TS_WIDTH(32), .TB_WIDTH(32),
        .LOG_GVT_PERIOD(5), .TIMEOUT_CYCLES(256)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .lvt_req(lvt_req), .lvt_valid(lvt_valid),
        .lvt_ts(lvt_ts), .lvt_tb(lvt_tb),
        .gvt_ts(gvt_ts), .gvt_tb(gvt_tb), .gvt_valid(gvt_valid),
        .all_idle(all_idle), .mono_err(mono_err),
        .timeout_err(timeout_err), .gvt_rounds(gvt_rounds)
    );

    always #5 clk = ~clk;

    // Tile model: respond once the request has been up for dly cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) age[i] <= lvt_req[i] ? age[i] + 1 : 0;
    end

    always_comb begin
        lvt_valid = '0;
        lvt_ts    = '0;
        lvt_tb    = '0;
        for (int i = 0; i < N; i++) begin
            lvt_valid[i]         = lvt_req[i] && !mute[i] && (age[i] >= dly[i]);
            lvt_ts[i*32 +: 32]   = tile_ts[i];
            lvt_tb[i*32 +: 32]   = tile_tb[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int k,
                           input logic [31:0] t0, t1, t2, t3,
                           input logic [31:0] b0, b1, b2, b3,
                           input int d2,
                           input logic [31:0] ets, etb,
                           input bit eidle, emono);
        vecs[k].ts[0] = t0; vecs[k].ts[1] = t1; vecs[k].ts[2] = t2; vecs[k].ts[3] = t3;
        vecs[k].tb[0] = b0; vecs[k].tb[1] = b1; vecs[k].tb[2] = b2; vecs[k].tb[3] = b3;
        for (int i = 0; i < N; i++) vecs[k].dly[i] = 0;
        vecs[k].dly[2] = d2;
        vecs[k].ets = ets; vecs[k].etb = etb;
        vecs[k].eidle = eidle; vecs[k].emono = emono;
    endtask

    task automatic load_tiles(input logic [31:0] t, input logic [31:0] b);
        for (int i = 0; i < N; i++) begin
            tile_ts[i] = t + 32'(i);
            tile_tb[i] = b;
            dly[i]     = 0;
        end
    endtask

    // Both waits start at a negedge and return at the negedge of the event.
    task automatic wait_req(input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            if (|lvt_req) begin
                at = cyc - base;
                break;
            end
            @(negedge clk);
        end
        chk("req_rise_seen", (at >= 0), 1);
    endtask

    task automatic wait_valid(input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            if (gvt_valid) begin
                at = cyc - base;
                break;
            end
            @(negedge clk);
        end
        chk("gvt_valid_seen", (at >= 0), 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_lvt_req"},     lvt_req,     0);
        chk({tag, "_gvt_ts"},      gvt_ts,      0);
        chk({tag, "_gvt_tb"},      gvt_tb,      0);
        chk({tag, "_gvt_valid"},   gvt_valid,   0);
        chk({tag, "_all_idle"},    all_idle,    0);
        chk({tag, "_mono_err"},    mono_err,    0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_gvt_rounds"},  gvt_rounds,  0);
    endtask

    initial begin
        int r, at, maxd, miss, spur, tout;
        logic [N-1:0] emask;

        rst    = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < N; i++) begin
            mute[i] = 1'b0;
            age[i]  = 0;
        end
        load_tiles(32'd0, 32'd0);

        //           ts0   ts1   ts2   ts3    tb0 tb1 tb2 tb3  d2  exp_ts exp_tb idle mono
        set_vec(0,   40,   12,   12,   90,    1,  7,  3,  0,   0,  12,    3,     0,   0);
        set_vec(1,   60,   70,   50,   80,    0,  0,  0,  5,   10, 50,    0,     0,   0);
        set_vec(2,   50,   50,   99,   50,    0,  1,  0,  2,   0,  50,    0,     0,   0);
        set_vec(3,   30,   40,   40,   40,    0,  0,  0,  0,   0,  50,    0,     0,   1);
        set_vec(4,   70,   70,   70,   70,    9,  4,  4,  8,   0,  70,    4,     0,   1);
        set_vec(5,   '1,   '1,   '1,   '1,    '1, '1, '1, '1,  0,  '1,    '1,    1,   1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        base = cyc;
        chk_reset_state("reset");

        for (int v = 0; v < NV; v++) begin
            maxd  = 0;
            emask = '0;
            for (int i = 0; i < N; i++) begin
                tile_ts[i] = vecs[v].ts[i];
                tile_tb[i] = vecs[v].tb[i];
                dly[i]     = vecs[v].dly[i];
                if (dly[i] > maxd) maxd = dly[i];
                emask[i] = (dly[i] != 0);
            end
            wait_req(100, r);
            if (v == 0) chk("first_req_cycle", r, 33);
            @(negedge clk);
            chk($sformatf("v%0d_req_after_accept", v), lvt_req, emask);
            wait_valid(100, at);
            chk($sformatf("v%0d_bcast_latency", v), at - r, 6 + maxd);
            if (v == 0) chk("first_bcast_cycle", at, 39);
            chk($sformatf("v%0d_gvt_ts", v),      gvt_ts,      vecs[v].ets);
            chk($sformatf("v%0d_gvt_tb", v),      gvt_tb,      vecs[v].etb);
            chk($sformatf("v%0d_all_idle", v),    all_idle,    vecs[v].eidle);
            chk($sformatf("v%0d_mono_err", v),    mono_err,    vecs[v].emono);
            chk($sformatf("v%0d_gvt_rounds", v),  gvt_rounds,  v + 1);
            chk($sformatf("v%0d_timeout_err", v), timeout_err, 0);
            @(negedge clk);
            chk($sformatf("v%0d_valid_one_cycle", v), gvt_valid, 0);
        end

        // Tile 3 never answers: round is abandoned after 256 COLLECT cycles.
        mute[3] = 1'b1;
        wait_req(100, r);
        miss = 0;
        spur = 0;
        tout = -1;
        for (int k = 0; k < 400; k++) begin
            if (timeout_err) begin
                tout = cyc - base;
                break;
            end
            if (gvt_valid)   spur++;
            if (!lvt_req[3]) miss++;
            @(negedge clk);
        end
        chk("timeout_cycle", tout - r, 255);
        chk("timeout_req3_held", miss, 0);
        chk("timeout_no_bcast", spur, 0);
        chk("timeout_req_dropped", lvt_req, 0);
        chk("timeout_gvt_valid", gvt_valid, 0);
        chk("timeout_rounds", gvt_rounds, 6);
        mute[3] = 1'b0;

        // enable drops during REDUCE: round still broadcasts, then stays idle.
        wait_req(100, r);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        wait_valid(50, at);
        chk("disable_bcast_latency", at - r, 6);
        chk("disable_rounds", gvt_rounds, 7);
        chk("disable_gvt_ts", gvt_ts, 32'hFFFF_FFFF);
        miss = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if ((|lvt_req) || gvt_valid) miss++;
        end
        chk("disable_quiet", miss, 0);

        // Reset in the middle of COLLECT restores every output.
        for (int i = 0; i < N; i++) mute[i] = 1'b1;
        enable = 1'b1;
        wait_req(100, r);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("rst_collect");
        rst  = 1'b0;
        base = cyc;
        for (int i = 0; i < N; i++) mute[i] = 1'b0;
        load_tiles(32'd5, 32'd0);
        wait_req(100, r);
        chk("post_rst_req_cycle", r, 33);
        @(negedge clk);
        wait_valid(100, at);
        chk("post_rst_bcast_cycle", at, 39);
        chk("post_rst_gvt_ts", gvt_ts, 5);
        chk("post_rst_gvt_tb", gvt_tb, 0);
        chk("post_rst_rounds", gvt_rounds, 1);
        chk("post_rst_mono", mono_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
